// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS-style datapath sharing one unified memory.
// Outputs are decoded from the state register so reset clears them immediately.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state;
  logic   pc_write;
  logic   branch;

  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_to_alu = ALU_ADD;
      6'b100010: funct_to_alu = ALU_SUB;
      6'b100100: funct_to_alu = ALU_AND;
      6'b100101: funct_to_alu = ALU_OR;
      6'b101010: funct_to_alu = ALU_SLT;
      default:   funct_to_alu = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:      state <= S_FETCH;
        S_FETCH:    state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state <= mem_ready ? S_MEMWB : S_MEMREAD;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: state <= mem_ready ? S_FETCH : S_MEMWRITE;
        S_EXECUTE:  state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_ADDIEX:   state <= S_ADDIWB;
        S_ADDIWB:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        default:    state <= S_RST;
      endcase
    end
  end

  // FETCH only commits IR and PC in the cycle memory actually completes.
  always_comb begin
    mem_req     = 1'b0;
    i_or_d      = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        if (!(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J})) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_to_alu(funct);
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = 1'b1;
        instr_done  = 1'b1;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors per instruction class.
// Outputs are packed into one vector and compared against hand-built expectations.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, i_or_d, mem_write, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal_op;

  int vectors = 0;
  int miscompares = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .i_or_d(i_or_d),
    .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // {mem_req,i_or_d,mem_write,ir_write,pc_en,pc_src,alu_src_a,alu_src_b,alu_control,
  //  reg_write,reg_dst,mem_to_reg,instr_done,illegal_op}
  logic [17:0] outs;
  assign outs = {mem_req, i_or_d, mem_write, ir_write, pc_en, pc_src, alu_src_a,
                 alu_src_b, alu_control, reg_write, reg_dst, mem_to_reg,
                 instr_done, illegal_op};

  localparam logic [17:0] E_ZERO       = 18'd0;
  localparam logic [17:0] E_FETCH_RDY  = {5'b10011, 2'b00, 1'b0, 2'b01, 3'b010, 5'b00000};
  localparam logic [17:0] E_FETCH_WAIT = {5'b10000, 2'b00, 1'b0, 2'b01, 3'b010, 5'b00000};
  localparam logic [17:0] E_DECODE     = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 5'b00000};
  localparam logic [17:0] E_DECODE_ILL = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 5'b00011};
  localparam logic [17:0] E_MEMADR     = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 5'b00000};
  localparam logic [17:0] E_MEMREAD    = {5'b11000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00000};
  localparam logic [17:0] E_MEMWB      = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b10110};
  localparam logic [17:0] E_MEMWR_WAIT = {5'b11100, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00000};
  localparam logic [17:0] E_MEMWR_DONE = {5'b11100, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00010};
  localparam logic [17:0] E_ALUWB      = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b11010};
  localparam logic [17:0] E_BRANCH_T   = {5'b00001, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00010};
  localparam logic [17:0] E_BRANCH_NT  = {5'b00000, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00010};
  localparam logic [17:0] E_ADDIWB     = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b10010};
  localparam logic [17:0] E_JUMP       = {5'b00001, 2'b10, 1'b0, 2'b00, 3'b000, 5'b00010};

  // Inputs change 1 time unit after each rising edge; outputs are sampled 2 units later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    vectors++;
    if (outs !== E_ZERO) begin
      miscompares++;
      $display("[TB] FAIL reset_hold got=%b want=%b", outs, E_ZERO);
    end
    tick();
    reset = 1'b0;
    #2;
    vectors++;
    if (outs !== E_ZERO) begin
      miscompares++;
      $display("[TB] FAIL rst_state got=%b want=%b", outs, E_ZERO);
    end
    tick();
    #2;
    vectors++;
    if (outs !== E_FETCH_WAIT) begin
      miscompares++;
      $display("[TB] FAIL first_fetch got=%b want=%b", outs, E_FETCH_WAIT);
    end
    tick();
  endtask

  task automatic test_lw;
    logic [17:0] exp_seq [5] = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB};
    op = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      if (i >= 3) op = 6'b111111;
      #2;
      vectors++;
      if (outs !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL lw_cycle%0d got=%b want=%b", i, outs, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw_wait;
    logic        rdy_seq [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [17:0] exp_seq [7] = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMWR_WAIT,
                                 E_MEMWR_WAIT, E_MEMWR_WAIT, E_MEMWR_DONE};
    op = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy_seq[i];
      if (i >= 3) op = 6'b100011;
      #2;
      vectors++;
      if (outs !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL sw_cycle%0d got=%b want=%b", i, outs, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_rtype;
    logic [5:0] f_tab [6] = '{6'b101010, 6'b100010, 6'b100100, 6'b100101, 6'b100000, 6'b000111};
    logic [2:0] a_tab [6] = '{3'b111, 3'b110, 3'b000, 3'b001, 3'b010, 3'b010};
    logic [17:0] exp_v;
    op = 6'b000000;
    mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      funct = f_tab[k];
      for (int i = 0; i < 4; i++) begin
        case (i)
          0:       exp_v = E_FETCH_RDY;
          1:       exp_v = E_DECODE;
          2:       exp_v = {5'b00000, 2'b00, 1'b1, 2'b00, a_tab[k], 5'b00000};
          default: exp_v = E_ALUWB;
        endcase
        #2;
        vectors++;
        if (outs !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL rtype_f%b_cycle%0d got=%b want=%b", f_tab[k], i, outs, exp_v);
        end
        tick();
      end
    end
  endtask

  task automatic test_branch;
    logic [17:0] exp_v;
    op = 6'b000100;
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       exp_v = E_FETCH_RDY;
          1:       exp_v = E_DECODE;
          default: exp_v = (k == 0) ? E_BRANCH_T : E_BRANCH_NT;
        endcase
        #2;
        vectors++;
        if (outs !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL beq_z%0d_cycle%0d got=%b want=%b", zero, i, outs, exp_v);
        end
        tick();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi_jump;
    logic [17:0] addi_seq [4] = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_ADDIWB};
    logic [17:0] j_seq [3]    = '{E_FETCH_RDY, E_DECODE, E_JUMP};
    mem_ready = 1'b1;
    op = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      #2;
      vectors++;
      if (outs !== addi_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL addi_cycle%0d got=%b want=%b", i, outs, addi_seq[i]);
      end
      tick();
    end
    op = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++;
      if (outs !== j_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL jump_cycle%0d got=%b want=%b", i, outs, j_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal;
    logic        rdy_seq [3] = '{1'b1, 1'b1, 1'b0};
    logic [17:0] exp_seq [3] = '{E_FETCH_RDY, E_DECODE_ILL, E_FETCH_WAIT};
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy_seq[i];
      #2;
      vectors++;
      if (outs !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL illegal_cycle%0d got=%b want=%b", i, outs, exp_seq[i]);
      end
      tick();
    end
  endtask

  // lw with fetch and read stalls; mem_ready low in DECODE/MEMADR must not stall.
  task automatic test_back_to_back;
    logic        rdy_seq [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [17:0] exp_seq [9] = '{E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_RDY, E_DECODE,
                                 E_MEMADR, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB};
    op = 6'b100011;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy_seq[i];
      #2;
      vectors++;
      if (outs !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL stall_lw_cycle%0d got=%b want=%b", i, outs, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_memread;
    logic [17:0] exp_seq [4] = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMREAD};
    op = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i < 3);
      #2;
      vectors++;
      if (outs !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL pre_reset_cycle%0d got=%b want=%b", i, outs, exp_seq[i]);
      end
      if (i < 3) tick();
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (outs !== E_ZERO) begin
      miscompares++;
      $display("[TB] FAIL async_reset got=%b want=%b", outs, E_ZERO);
    end
    tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    #2;
    vectors++;
    if (outs !== E_ZERO) begin
      miscompares++;
      $display("[TB] FAIL post_reset_rst got=%b want=%b", outs, E_ZERO);
    end
    tick();
    #2;
    vectors++;
    if (outs !== E_FETCH_WAIT) begin
      miscompares++;
      $display("[TB] FAIL post_reset_fetch got=%b want=%b", outs, E_FETCH_WAIT);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_branch();
    test_addi_jump();
    test_illegal();
    test_back_to_back();
    test_reset_mid_memread();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
